cos_correlator_rx: RTL and testbench

- Receive-side counterpart of the I-arm cosine wave generator.
- Correlates incoming signed 8-bit carrier samples against a local 52-entry cosine table, one table period per symbol.
- At each symbol boundary, decides the transmitted bit from the sign of the correlation (1 = in-phase cosine, 0 = 180-degree-shifted cosine).
- Sits after the channel/ADC sample stream; feeds the QPSK bit recombiner.

---
 rtl/cos_correlator_rx.sv | 125 ++++++++++++
 tb/tb_cos_correlator_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cos_correlator_rx.sv
// Correlates signed 8-bit carrier samples against a 52-entry cosine table; decides one bit per symbol from the sign.
// Optional erasure flag on weak correlations when COSDEMOD_ERASURE_EN is defined.
module cos_correlator_rx #(
   parameter int SAMPLES_PER_SYM = 52,
   parameter int ACC_W           = 22,
   parameter int CNT_W           = 16,
   parameter int ERASE_THR       = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       sample_in,
   input  logic             sample_valid,
   input  logic             sym_sync,
   output logic             bit_out,
   output logic             bit_valid,
   output logic [ACC_W-1:0] corr_out,
   output logic [CNT_W-1:0] sym_cnt
`ifdef COSDEMOD_ERASURE_EN
   ,
   output logic             bit_erasure
`endif
);

   localparam logic [5:0] LAST_IDX = 6'(SAMPLES_PER_SYM - 1);

   // The table depth is fixed, so any other symbol length cannot work.
   if (SAMPLES_PER_SYM != 52 || ERASE_THR <= 0) begin : g_bad_cfg
      $error("cos_correlator_rx: unsupported SAMPLES_PER_SYM or ERASE_THR");
   end

   function automatic logic signed [7:0] cos_half(input logic [4:0] i);
      case (i)
         5'd0:    return 8'sd78;
         5'd1:    return 8'sd77;
         5'd2:    return 8'sd75;
         5'd3:    return 8'sd73;
         5'd4:    return 8'sd69;
         5'd5:    return 8'sd64;
         5'd6:    return 8'sd58;
         5'd7:    return 8'sd51;
         5'd8:    return 8'sd44;
         5'd9:    return 8'sd36;
         5'd10:   return 8'sd27;
         5'd11:   return 8'sd18;
         5'd12:   return 8'sd9;
         5'd13:   return 8'sd0;
         5'd14:   return -8'sd9;
         5'd15:   return -8'sd18;
         5'd16:   return -8'sd27;
         5'd17:   return -8'sd36;
         5'd18:   return -8'sd44;
         5'd19:   return -8'sd51;
         5'd20:   return -8'sd58;
         5'd21:   return -8'sd64;
         5'd22:   return -8'sd69;
         5'd23:   return -8'sd73;
         5'd24:   return -8'sd75;
         default: return -8'sd77;
      endcase
   endfunction

   // Second half of the period is the first half negated.
   function automatic logic signed [7:0] cos_lut(input logic [5:0] i);
      if (i < 6'd26) return cos_half(i[4:0]);
      else           return -cos_half(5'(i - 6'd26));
   endfunction

   logic        [5:0]       idx;
   logic signed [ACC_W-1:0] acc;
   logic        [5:0]       idx_sel;
   logic signed [ACC_W-1:0] acc_base;
   logic signed [7:0]       coef;
   logic signed [15:0]      prod;
   logic signed [ACC_W-1:0] sum;
   logic                    decide;

   // A sync with a valid sample restarts the symbol using this very sample as index 0.
   always_comb begin
      idx_sel  = sym_sync ? 6'd0 : idx;
      acc_base = sym_sync ? '0 : acc;
      coef     = cos_lut(idx_sel);
      prod     = $signed(sample_in) * coef;
      sum      = acc_base + {{(ACC_W-16){prod[15]}}, prod};
      decide   = sample_valid && !sym_sync && (idx == LAST_IDX);
   end

`ifdef COSDEMOD_ERASURE_EN
   logic [ACC_W-1:0] mag;
   always_comb mag = sum[ACC_W-1] ? -sum : sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         acc       <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         corr_out  <= '0;
         sym_cnt   <= '0;
`ifdef COSDEMOD_ERASURE_EN
         bit_erasure <= 1'b0;
`endif
      end else begin
         bit_valid <= 1'b0;
         if (decide) begin
            corr_out  <= sum;
            bit_out   <= !sum[ACC_W-1] && (sum != '0);
            bit_valid <= 1'b1;
            if (sym_cnt != '1) sym_cnt <= sym_cnt + CNT_W'(1);
`ifdef COSDEMOD_ERASURE_EN
            bit_erasure <= (mag < ACC_W'(ERASE_THR));
`endif
            acc <= '0;
            idx <= '0;
         end else if (sample_valid) begin
            acc <= sum;
            idx <= idx_sel + 6'd1;
         end else if (sym_sync) begin
            acc <= '0;
            idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cos_correlator_rx.sv
// Scoreboard bench for cos_correlator_rx: directed symbols push expected decisions, a negedge monitor checks each bit_valid pulse.
module tb_cos_correlator_rx;

   localparam int ACC_W = 22;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       sample_in;
   logic             sample_valid;
   logic             sym_sync;
   logic             bit_out;
   logic             bit_valid;
   logic [ACC_W-1:0] corr_out;
   logic [CNT_W-1:0] sym_cnt;
`ifdef COSDEMOD_ERASURE_EN
   logic             bit_erasure;
`endif

   cos_correlator_rx #(.SAMPLES_PER_SYM(52), .ACC_W(ACC_W), .CNT_W(CNT_W), .ERASE_THR(4096)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sym_sync     (sym_sync),
      .bit_out      (bit_out),
      .bit_valid    (bit_valid),
      .corr_out     (corr_out),
      .sym_cnt      (sym_cnt)
`ifdef COSDEMOD_ERASURE_EN
      ,
      .bit_erasure  (bit_erasure)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      longint corr;
      longint bitv;
      longint cnt;
      longint eras;
   } exp_t;

   exp_t   exp_q[$];
   longint cyc_q[$];
   longint cyc = 0;
   int     n_chk = 0;
   int     n_fail = 0;
   int     acc_n = 0;
   int     half[26] = '{78, 77, 75, 73, 69, 64, 58, 51, 44, 36, 27, 18, 9,
                        0, -9, -18, -27, -36, -44, -51, -58, -64, -69, -73, -75, -77};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cos_of(input int i);
      return (i < 26) ? half[i] : -half[i - 26];
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Drives one cycle; records the cycle in which a decision must appear.
   task automatic drive(input int s, input logic v, input logic sy);
      sample_in    = 8'(s);
      sample_valid = v;
      sym_sync     = sy;
      @(posedge clk);
      #1;
      if (v) begin
         acc_n = sy ? 1 : acc_n + 1;
         if (acc_n == 52) begin
            cyc_q.push_back(cyc);
            acc_n = 0;
         end
      end else if (sy) begin
         acc_n = 0;
      end
      sample_in    = 8'h55;
      sample_valid = 1'b0;
      sym_sync     = 1'b0;
   endtask

   task automatic expect_dec(input longint corr, input longint bitv, input longint cnt, input longint eras);
      exp_t e;
      e.corr = corr; e.bitv = bitv; e.cnt = cnt; e.eras = eras;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_state();
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_corr_out", corr_out, 0);
      check("rst_sym_cnt", sym_cnt, 0);
`ifdef COSDEMOD_ERASURE_EN
      check("rst_bit_erasure", bit_erasure, 0);
`endif
   endtask

   // Monitor: every pulse must match the oldest pending expectation, in the predicted cycle.
   always @(negedge clk) begin
      if (reset && bit_valid) begin
         if (exp_q.size() == 0 || cyc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: got bit_valid=1 at cycle %0d, required no pulse", cyc);
         end else begin
            exp_t   e;
            longint c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("pulse_cycle", cyc, c);
            check("corr_out", longint'($signed(corr_out)), e.corr);
            check("bit_out", bit_out, e.bitv);
            check("sym_cnt", sym_cnt, e.cnt);
`ifdef COSDEMOD_ERASURE_EN
            check("bit_erasure", bit_erasure, e.eras);
`endif
         end
      end
   end

   initial begin
      int gaps_left;
      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      sym_sync     = 1'b0;
      #1 reset = 1'b0;
      #2 check_reset_state();
      #20 reset = 1'b1;
      @(posedge clk); #1;

      // In-phase symbol
      expect_dec(156452, 1, 1, 0);
      for (int i = 0; i < 52; i++) drive(cos_of(i), 1'b1, 1'b0);

      // Anti-phase symbol
      expect_dec(-156452, 0, 2, 0);
      for (int i = 0; i < 52; i++) drive(cos_of((i + 26) % 52), 1'b1, 1'b0);

      // Constant: zero correlation, tie decides 0, weak
      expect_dec(0, 0, 3, 1);
      for (int i = 0; i < 52; i++) drive(127, 1'b1, 1'b0);

      // Realign with valid after 20 samples
      expect_dec(156452, 1, 4, 0);
      for (int i = 0; i < 20; i++) drive(cos_of(i), 1'b1, 1'b0);
      drive(cos_of(0), 1'b1, 1'b1);
      for (int i = 1; i < 52; i++) drive(cos_of(i), 1'b1, 1'b0);

      // In-phase with 10 idle cycles scattered through the symbol
      expect_dec(156452, 1, 5, 0);
      gaps_left = 10;
      for (int i = 0; i < 52; i++) begin
         while (gaps_left > 0 && ($urandom_range(0, 3) == 0 || gaps_left >= 52 - i)) begin
            drive(8'h55, 1'b0, 1'b0);
            gaps_left--;
         end
         drive(cos_of(i), 1'b1, 1'b0);
      end

      // Realign without valid after a partial anti-phase symbol
      expect_dec(156452, 1, 6, 0);
      for (int i = 0; i < 15; i++) drive(cos_of(i + 26), 1'b1, 1'b0);
      drive(0, 1'b0, 1'b1);
      for (int i = 0; i < 52; i++) drive(cos_of(i), 1'b1, 1'b0);

      // Reset in the middle of a symbol
      for (int i = 0; i < 30; i++) drive(cos_of(i), 1'b1, 1'b0);
      reset = 1'b0;
      acc_n = 0;
      #1 check_reset_state();
      #2 reset = 1'b1;
      @(posedge clk); #1;
      expect_dec(156452, 1, 1, 0);
      for (int i = 0; i < 52; i++) drive(cos_of(i), 1'b1, 1'b0);

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("pending_decisions", exp_q.size(), 0);
      check("pending_cycles", cyc_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
